// File: rtl/controle_venda.sv
// controle_venda: payment/dispense controller downstream of the product selector.
// It accumulates coin credit and latches the selection on confirm. It then
// dispenses, returns change, and handles cancel/refund.
// Optional build macro CV_TIMEOUT_EN adds an idle timeout in COBRANDO that
// refunds the credit automatically after TIMEOUT_CYC cycles without a coin.
module controle_venda #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 15,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          valor,
  input  logic [3:0]          codeOut,
  input  logic                existe,
  input  logic                confirmar,
  input  logic                cancelar,
  input  logic                moeda_valid,
  input  logic [2:0]          moeda_val,
  output logic [CREDIT_W-1:0] credito,
  output logic                liberar,
  output logic [3:0]          produto,
  output logic [CREDIT_W-1:0] troco,
  output logic                troco_valid,
  output logic                moeda_rejeitada,
  output logic                erro,
  output logic                ocupado
);

  // FSM encoding
  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] COBRANDO = 3'd1;
  localparam logic [2:0] LIBERA   = 3'd2;
  localparam logic [2:0] TROCO    = 3'd3;
  localparam logic [2:0] DEVOLVE  = 3'd4;

  localparam logic [3:0] NO_PRODUCT = 4'b1111;

  // Architectural state
  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credito_q, credito_d;
  logic [2:0]          preco_q, preco_d;
  logic [3:0]          produto_q, produto_d;
  logic [CREDIT_W-1:0] troco_q, troco_d;

  // Registered strobes / status
  logic liberar_q, liberar_d;
  logic troco_valid_q, troco_valid_d;
  logic moeda_rej_q, moeda_rej_d;
  logic erro_q, erro_d;
  logic ocupado_q, ocupado_d;

  // Coin path signals
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_window;
  logic                cancel_take;
  logic                coin_ok;
  logic                coin_accept;
  logic                coin_reject;

  // Price comparison / dispense arithmetic
  logic [CREDIT_W-1:0] preco_ext;
  logic                credit_enough;
  logic [CREDIT_W-1:0] remainder;

  // Timeout request (always 0 when the feature is compiled out)
  logic                timeout_hit;

  // Coin acceptance: the sum is one bit wider than credit, so overflow never wraps
  always_comb begin
    coin_sum    = {1'b0, credito_q} + (CREDIT_W+1)'(moeda_val);
    coin_window = (state_q == OCIOSO) || (state_q == COBRANDO);
    cancel_take = cancelar && coin_window;
    coin_ok     = coin_window && (moeda_val != 3'd0) &&
                  (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    // A cancel in the same cycle wins over the coin, so the coin is handed back
    coin_accept = moeda_valid && coin_ok && !cancel_take;
    coin_reject = moeda_valid && !coin_accept;
  end

  // Price comparison against the registered credit, and change computation
  always_comb begin
    preco_ext     = CREDIT_W'(preco_q);
    credit_enough = (credito_q >= preco_ext);
    remainder     = credito_q - preco_ext;
  end

`ifdef CV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle counter: restarts on entry to COBRANDO and on every accepted coin
  always_comb begin
    to_cnt_d    = '0;
    // Fires in the cycle where the counter would reach TIMEOUT_CYC
    timeout_hit = (state_q == COBRANDO) &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    if (state_q == COBRANDO && state_d == COBRANDO && !coin_accept) begin
      if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_d = to_cnt_q;
      end
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout, COBRANDO waits indefinitely for credit or cancel
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // Main FSM: next state, credit/selection updates and the strobes for the next cycle
  always_comb begin
    state_d       = state_q;
    credito_d     = credito_q;
    preco_d       = preco_q;
    produto_d     = produto_q;
    troco_d       = troco_q;
    liberar_d     = 1'b0;
    troco_valid_d = 1'b0;
    erro_d        = 1'b0;
    moeda_rej_d   = coin_reject;

    if (coin_accept) begin
      credito_d = coin_sum[CREDIT_W-1:0];
    end

    case (state_q)
      OCIOSO: begin
        if (cancelar) begin
          state_d       = DEVOLVE;
          troco_valid_d = 1'b1;
          troco_d       = credito_q;
        end else if (confirmar) begin
          if (existe) begin
            preco_d   = valor;
            produto_d = codeOut;
            state_d   = COBRANDO;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      COBRANDO: begin
        // confirmar and selector changes are deliberately ignored here
        if (cancelar) begin
          state_d       = DEVOLVE;
          troco_valid_d = 1'b1;
          troco_d       = credito_q;
        end else if (credit_enough) begin
          state_d   = LIBERA;
          liberar_d = 1'b1;
        end else if (timeout_hit && !coin_accept) begin
          state_d       = DEVOLVE;
          troco_valid_d = 1'b1;
          troco_d       = credito_q;
        end
      end

      LIBERA: begin
        // Dispense is not abortable; a cancel here is dropped
        credito_d = remainder;
        if (remainder != '0) begin
          state_d       = TROCO;
          troco_valid_d = 1'b1;
          troco_d       = remainder;
        end else begin
          state_d = OCIOSO;
        end
      end

      TROCO, DEVOLVE: begin
        credito_d = '0;
        state_d   = OCIOSO;
      end

      default: begin
        state_d   = OCIOSO;
        credito_d = '0;
      end
    endcase

    ocupado_d = (state_d != OCIOSO);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OCIOSO;
      credito_q     <= '0;
      preco_q       <= '0;
      produto_q     <= NO_PRODUCT;
      troco_q       <= '0;
      liberar_q     <= 1'b0;
      troco_valid_q <= 1'b0;
      moeda_rej_q   <= 1'b0;
      erro_q        <= 1'b0;
      ocupado_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credito_q     <= credito_d;
      preco_q       <= preco_d;
      produto_q     <= produto_d;
      troco_q       <= troco_d;
      liberar_q     <= liberar_d;
      troco_valid_q <= troco_valid_d;
      moeda_rej_q   <= moeda_rej_d;
      erro_q        <= erro_d;
      ocupado_q     <= ocupado_d;
    end
  end

  assign credito         = credito_q;
  assign liberar         = liberar_q;
  assign produto         = produto_q;
  assign troco           = troco_q;
  assign troco_valid     = troco_valid_q;
  assign moeda_rejeitada = moeda_rej_q;
  assign erro            = erro_q;
  assign ocupado         = ocupado_q;

endmodule
